// File: rtl/path_streamer.sv
// path_streamer: streams a stored path one {x,y} coordinate per valid/ready
// transfer, forward or reverse, with optional suppression of consecutive
// duplicates, abort, and clamping of the requested length to MAX_LEN.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; request fields captured when start is seen
// LOAD  | fetch path[idx] into the output register or skip a duplicate
// SEND  | coord_valid high, coord_out held until the consumer takes it
// DONE  | stream complete; finished pulses on the following cycle
module path_streamer #(
    parameter int COORD_W = 16,
    parameter int MAX_LEN = 100,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [MAX_LEN*2*COORD_W-1:0] path,
    input  logic [LEN_W-1:0]           length,
    input  logic                       reverse,
    input  logic                       skip_dup,
    input  logic                       abort,
    input  logic                       coord_ready,
    output logic                       coord_valid,
    output logic [2*COORD_W-1:0]       coord_out,
    output logic                       coord_last,
    output logic                       busy,
    output logic                       finished,
    output logic                       aborted,
    output logic                       clamped,
    output logic [LEN_W-1:0]           count
);

    localparam int EW = 2 * COORD_W;
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_V     = LEN_W'(1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

    state_t state, state_nxt;

    logic [LEN_W-1:0] len_cap;
    logic [LEN_W-1:0] len_in_cap;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] idx_step;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] count_r;
    logic             rev_r;
    logic             skip_r;
    logic             have_emit;
    logic [EW-1:0]    last_emit;
    logic [EW-1:0]    coord_r;
    logic [EW-1:0]    elem_cur;
    logic             tail_dup;
    logic             skip_now;
    logic             xfer;
    logic             finished_r;
    logic             aborted_r;
    logic             clamped_r;

    assign len_in_cap = (length > MAX_LEN_V) ? MAX_LEN_V : length;
    assign idx_step   = rev_r ? (idx - ONE_V) : (idx + ONE_V);

    // Select the element addressed by idx from the flattened path bus.
    always_comb begin
        elem_cur = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (idx == LEN_W'(k)) begin
                elem_cur = path[k*EW +: EW];
            end
        end
    end

    // True when every element still to be visited equals the one on the
    // output; with skip_dup those would all be suppressed, so the current
    // coordinate is really the final one.
    always_comb begin
        tail_dup = 1'b1;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (rev_r ? (LEN_W'(k) < idx)
                      : ((LEN_W'(k) > idx) && (LEN_W'(k) < len_cap))) begin
                if (path[k*EW +: EW] != coord_r) begin
                    tail_dup = 1'b0;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus the per-cycle skip and transfer decisions.
    always_comb begin
        state_nxt = state;
        skip_now  = 1'b0;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len_in_cap == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                skip_now = skip_r && have_emit && (elem_cur == last_emit);
                if (abort) begin
                    state_nxt = IDLE;
                end else if (skip_now) begin
                    state_nxt = (remaining == ONE_V) ? DONE : LOAD;
                end else begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                xfer = coord_ready;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (xfer) begin
                    state_nxt = (remaining == ONE_V) ? DONE : LOAD;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: request capture, index walk, output register, status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            len_cap    <= '0;
            idx        <= '0;
            remaining  <= '0;
            count_r    <= '0;
            rev_r      <= 1'b0;
            skip_r     <= 1'b0;
            have_emit  <= 1'b0;
            last_emit  <= '0;
            coord_r    <= '0;
            finished_r <= 1'b0;
            aborted_r  <= 1'b0;
            clamped_r  <= 1'b0;
        end else begin
            finished_r <= (state == DONE);
            aborted_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_cap   <= len_in_cap;
                        rev_r     <= reverse;
                        skip_r    <= skip_dup;
                        clamped_r <= (length > MAX_LEN_V);
                        count_r   <= '0;
                        have_emit <= 1'b0;
                        remaining <= len_in_cap;
                        idx       <= (reverse && (len_in_cap != '0))
                                     ? (len_in_cap - ONE_V) : '0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        aborted_r <= 1'b1;
                    end else begin
                        coord_r <= elem_cur;
                        if (skip_now) begin
                            remaining <= remaining - ONE_V;
                            if (remaining != ONE_V) begin
                                idx <= idx_step;
                            end
                        end
                    end
                end
                SEND: begin
                    if (abort) begin
                        aborted_r <= 1'b1;
                    end
                    // A transfer on the abort edge still counts.
                    if (xfer) begin
                        count_r   <= count_r + ONE_V;
                        last_emit <= coord_r;
                        have_emit <= 1'b1;
                        remaining <= remaining - ONE_V;
                        if (remaining != ONE_V) begin
                            idx <= idx_step;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign coord_valid = (state == SEND);
    assign coord_out   = coord_r;
    assign coord_last  = (state == SEND) &&
                         ((remaining == ONE_V) || (skip_r && tail_dup));
    assign busy        = (state == LOAD) || (state == SEND);
    assign finished    = finished_r;
    assign aborted     = aborted_r;
    assign clamped     = clamped_r;
    assign count       = count_r;

endmodule

// File: tb/tb_path_streamer.sv
// Testbench for path_streamer: a reference model expands each request into
// the expected coordinate sequence, which is queued and compared against
// every cycle the DUT presents coord_valid.
module tb_path_streamer;

    localparam int COORD_W = 16;
    localparam int MAX_LEN = 100;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int EW      = 2 * COORD_W;

    logic                     clk;
    logic                     reset;
    logic                     start;
    logic [MAX_LEN*EW-1:0]    path;
    logic [LEN_W-1:0]         length;
    logic                     reverse;
    logic                     skip_dup;
    logic                     abort;
    logic                     coord_ready;
    logic                     coord_valid;
    logic [EW-1:0]            coord_out;
    logic                     coord_last;
    logic                     busy;
    logic                     finished;
    logic                     aborted;
    logic                     clamped;
    logic [LEN_W-1:0]         count;

    logic [EW-1:0]            path_arr [MAX_LEN];
    logic [EW:0]              sb [$];
    int                       n_checks = 0;
    int                       n_fail   = 0;

    path_streamer #(.COORD_W(COORD_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .path(path), .length(length),
        .reverse(reverse), .skip_dup(skip_dup), .abort(abort),
        .coord_ready(coord_ready), .coord_valid(coord_valid),
        .coord_out(coord_out), .coord_last(coord_last), .busy(busy),
        .finished(finished), .aborted(aborted), .clamped(clamped), .count(count)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack the element array onto the flattened path bus.
    always_comb begin
        path = '0;
        for (int k = 0; k < MAX_LEN; k++) path[k*EW +: EW] = path_arr[k];
    end

    // Hard stop should a wait ever run away.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one stream from IDLE; called and returns at posedge+1.
    task automatic run_stream(input int len, input bit rev, input bit sd, input bit tog,
                              input int abort_after, input bit hold_start,
                              output int first_valid_c, output int fin_c, output int n_emit);
        int            n;
        int            c;
        int            n_xfer;
        int            fin_pulses;
        bit            end_seen;
        bit            abort_done;
        bit            have;
        logic [EW-1:0] prev;
        logic [EW-1:0] emits [$];
        logic [EW:0]   front;
        n = (len > MAX_LEN) ? MAX_LEN : len;
        have = 1'b0;
        prev = '0;
        for (int i = 0; i < n; i++) begin
            int k;
            k = rev ? (n - 1 - i) : i;
            if (!(sd && have && (path_arr[k] == prev))) begin
                emits.push_back(path_arr[k]);
                prev = path_arr[k];
                have = 1'b1;
            end
        end
        n_emit = emits.size();
        for (int i = 0; i < n_emit; i++) sb.push_back({(i == n_emit - 1), emits[i]});

        c = 0; n_xfer = 0; fin_pulses = 0; end_seen = 0; abort_done = 0;
        first_valid_c = -1; fin_c = -1;
        coord_ready = 1'b1;
        length = LEN_W'(len); reverse = rev; skip_dup = sd; start = 1'b1;
        @(posedge clk); #1;
        if (hold_start) length = LEN_W'(110);
        else start = 1'b0;

        while (!end_seen && c < 600) begin
            @(negedge clk);
            c++;
            check_eq("fin_with_valid", finished & coord_valid, 0);
            check_eq("fin_with_abort", finished & aborted, 0);
            if (coord_valid) begin
                if (first_valid_c < 0) first_valid_c = c;
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", coord_valid, 0);
                end else begin
                    front = sb[0];
                    check_eq("coord", coord_out, front[EW-1:0]);
                    check_eq("last", coord_last, front[EW]);
                    if (coord_ready) begin
                        void'(sb.pop_front());
                        n_xfer++;
                    end
                end
            end else begin
                check_eq("last_without_valid", coord_last, 0);
            end
            if (finished) begin
                fin_pulses++;
                fin_c = c;
                check_eq("count_at_finish", count, n_emit);
                end_seen = 1;
            end
            if (aborted) begin
                check_eq("valid_after_abort", coord_valid, 0);
                check_eq("count_at_abort", count, abort_after);
                end_seen = 1;
            end
            @(posedge clk); #1;
            abort = 1'b0;
            if (abort_after > 0 && n_xfer == abort_after && !abort_done) begin
                abort = 1'b1;
                abort_done = 1;
            end
            if (tog) coord_ready = ~coord_ready;
        end
        check_eq("stream_timeout", end_seen, 1);
        if (abort_after > 0) begin
            check_eq("no_finished_on_abort", fin_pulses, 0);
            sb.delete();
        end else begin
            check_eq("sb_drained", sb.size(), 0);
        end
        @(negedge clk);
        check_eq("finished_one_cycle", finished, 0);
        check_eq("aborted_one_cycle", aborted, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int fv, fc, ne;
        reset = 1'b0; start = 1'b0; length = '0; reverse = 1'b0; skip_dup = 1'b0;
        abort = 1'b0; coord_ready = 1'b0;
        for (int k = 0; k < MAX_LEN; k++) path_arr[k] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", coord_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_coord", coord_out, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        path_arr[0] = 32'h0010_0010; path_arr[1] = 32'h0040_0020; path_arr[2] = 32'h0082_0043;
        run_stream(3, 0, 0, 0, 0, 0, fv, fc, ne);
        check_eq("fwd_first_valid_cycle", fv, 2);
        check_eq("fwd_finished_cycle", fc, 8);

        run_stream(3, 1, 0, 1, 0, 0, fv, fc, ne);
        check_eq("rev_count", count, 3);

        path_arr[0] = 32'h0005_0005; path_arr[1] = 32'h0005_0005;
        path_arr[2] = 32'h0007_0009; path_arr[3] = 32'h0007_0009;
        run_stream(4, 0, 1, 0, 0, 0, fv, fc, ne);
        check_eq("skip_emits", ne, 2);
        check_eq("skip_count", count, 2);
        run_stream(4, 0, 0, 0, 0, 0, fv, fc, ne);
        check_eq("noskip_count", count, 4);
        run_stream(4, 1, 1, 1, 0, 0, fv, fc, ne);
        check_eq("rev_skip_count", count, 2);

        run_stream(0, 0, 0, 0, 0, 0, fv, fc, ne);
        check_eq("len0_no_valid", fv, -1);
        check_eq("len0_finished_cycle", fc, 2);

        for (int k = 0; k < MAX_LEN; k++) path_arr[k] = {16'(k + 1), 16'(3 * k + 7)};
        run_stream(MAX_LEN + 5, 0, 0, 0, 0, 0, fv, fc, ne);
        check_eq("clamp_count", count, MAX_LEN);
        check_eq("clamped_set", clamped, 1);
        check_eq("clamped_held", clamped, 1);

        run_stream(5, 0, 0, 0, 2, 0, fv, fc, ne);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_clamp_cleared", clamped, 0);
        check_eq("abort_count_held", count, 2);
        run_stream(5, 0, 0, 1, 0, 0, fv, fc, ne);
        check_eq("restream_count", count, 5);

        // start held high: ignored while busy, re-triggers (length 110) after DONE
        run_stream(4, 0, 0, 0, 0, 1, fv, fc, ne);
        start = 1'b0;
        @(negedge clk);
        check_eq("retrig_busy", busy, 1);
        check_eq("retrig_valid", coord_valid, 1);
        check_eq("retrig_coord0", coord_out, path_arr[0]);
        check_eq("retrig_clamped", clamped, 1);
        @(posedge clk); #1;
        coord_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("stall_valid", coord_valid, 1);
        check_eq("stall_coord1", coord_out, path_arr[1]);
        check_eq("stall_count", count, 1);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst_valid", coord_valid, 0);
        check_eq("midrst_coord", coord_out, 0);
        check_eq("midrst_last", coord_last, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_finished", finished, 0);
        check_eq("midrst_aborted", aborted, 0);
        check_eq("midrst_clamped", clamped, 0);
        check_eq("midrst_count", count, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        run_stream(3, 1, 0, 0, 0, 0, fv, fc, ne);
        check_eq("post_rst_count", count, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
